// File: rtl/seg7_pkg.sv
// Shared constants for the six-digit 7-segment scan stage: digit count, blank/dash patterns,
// decimal-point placement, display modes and the active-low BCD segment table.
package seg7_pkg;

  localparam int NDIG = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Digit indices 2 and 4 carry the point: hh.mm.ss / mm.ss.cc
  localparam logic [5:0] DP_MASK = 6'b010100;

  typedef enum logic [1:0] {
    MODE_CLOCK  = 2'd0,
    MODE_ALARM  = 2'd1,
    MODE_SWATCH = 2'd2,
    MODE_NONE   = 2'd3
  } mode_t;

  // {g,f,e,d,c,b,a}, active-low; codes 10-15 are blank
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decode; non-decimal codes come out blank.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern
  always_comb begin
    seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg7_scan6.sv
// Six-digit common-anode 7-segment scanner: per-frame digit snapshot, anti-ghosting guard,
// decimal points per mode and alarm blink, all outputs registered.
module seg7_scan6
  import seg7_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 6000,
  parameter int BLINK_HZ = 2,
  parameter int GUARD    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] a2,
  input  logic [3:0] a3,
  input  logic [3:0] a4,
  input  logic [3:0] a5,
  input  logic [3:0] a6,
  input  logic [1:0] Y,
  input  logic       twinkle,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW        = $clog2(SCAN_DIV);
  localparam int BW        = $clog2(BLINK_DIV);

  logic [PW-1:0] pre_r;
  logic [2:0]    idx_r;
  logic [BW-1:0] blink_cnt_r;
  logic          phase_r;
  logic [3:0]    snap_r [NDIG];
  mode_t         snap_mode_r;
  logic          snap_tw_r;

  logic          tick_s;
  logic [3:0]    cur_digit_s;
  logic [6:0]    dec_seg_s;
  logic [5:0]    onehot_s;
  logic [5:0]    an_nxt_s;
  logic [6:0]    seg_nxt_s;
  logic          dp_nxt_s;

  logic [5:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  assign tick_s = (pre_r == PW'(SCAN_DIV - 1));

  // Prescaler, digit index and frame snapshot taken on the 5->0 wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r       <= '0;
      idx_r       <= 3'd0;
      snap_r      <= '{default: 4'd0};
      snap_mode_r <= MODE_CLOCK;
      snap_tw_r   <= 1'b0;
    end else if (tick_s) begin
      pre_r <= '0;
      if (idx_r == 3'(NDIG - 1)) begin
        idx_r       <= 3'd0;
        snap_r      <= '{a, a2, a3, a4, a5, a6};
        snap_mode_r <= mode_t'(Y);
        snap_tw_r   <= twinkle;
      end else begin
        idx_r <= idx_r + 3'd1;
      end
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

  // Free-running blink half-period counter and on/off phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
      blink_cnt_r <= '0;
      phase_r     <= ~phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
    end
  end

  // Select the snapshot digit for the active slot
  always_comb begin
    case (idx_r)
      3'd0:    cur_digit_s = snap_r[0];
      3'd1:    cur_digit_s = snap_r[1];
      3'd2:    cur_digit_s = snap_r[2];
      3'd3:    cur_digit_s = snap_r[3];
      3'd4:    cur_digit_s = snap_r[4];
      3'd5:    cur_digit_s = snap_r[5];
      default: cur_digit_s = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit_s),
    .seg (dec_seg_s)
  );

  // Next anode/segment/point values from index, snapshot, guard and blink
  always_comb begin
    onehot_s = 6'(6'b000001 << idx_r);
    if (snap_mode_r == MODE_NONE) begin
      seg_nxt_s = SEG_DASH;
      dp_nxt_s  = 1'b1;
    end else begin
      seg_nxt_s = dec_seg_s;
      dp_nxt_s  = ~|(onehot_s & DP_MASK);
    end
    if ((pre_r < PW'(GUARD)) || (snap_tw_r && phase_r)) begin
      an_nxt_s = 6'b111111;
    end else begin
      an_nxt_s = ~onehot_s;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= 6'b111111;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule
